// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared encodings for the HI/LO multiply/divide unit.
//   op_e    : operation select carried on the op port
//   state_e : control FSM state encoding
//   op_is_div / op_is_signed : small decode helpers used by the datapath
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative MIPS-style multiply/divide unit with HI/LO registers.
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-low
//   start, op      launch MULT/MULTU/DIV/DIVU on operands a (rs), b (rt)
//   flush          abort the operation in flight (HI/LO untouched)
//   hi_we, lo_we   MTHI/MTLO strobes carrying wdata, honoured only while idle
//   busy           operation in flight
//   done, dz       one-cycle result pulse; dz flags divide-by-zero with done
//   hi, lo         architectural HI/LO registers
//
// Build option
//   MULDIV_FAST_MUL_EN : multiplies complete in one cycle (RUN skipped,
//                        busy stays low); divides keep the iterative timing.
//
// Handshake: start is a single-cycle request sampled on the rising edge and
// only accepted in IDLE; the core must hold off new requests while busy.
// done pulses exactly once per accepted, unflushed operation.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc: product high half / partial remainder; quo: multiplier / quotient
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;    // multiplicand or divisor magnitude
    logic             neg_q, neg_d;        // negate product / quotient
    logic             rneg_q, rneg_d;      // negate remainder (dividend was negative)
    logic             dzf_q, dzf_d;        // divisor was zero
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    // operand decode at acceptance
    op_e              op_in;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // one iteration of each algorithm
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;

    // final sign correction
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op_in = op_e'(op);
        a_neg = op_is_signed(op_in) && a[WIDTH-1];
        b_neg = op_is_signed(op_in) && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        // shift-add: add multiplicand when the multiplier LSB is set, then
        // shift the {carry, acc, quo} chain right by one
        mul_sum = {1'b0, acc_q} + {1'b0, (quo_q[0] ? mcand_q : '0)};

        // restoring divide: bring in the next dividend bit, subtract if it fits
        div_sh  = {acc_q, quo_q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, mcand_q};

        prod_raw = {acc_q, quo_q};
        prod_fix = (op_q == OP_MULT && neg_q) ? -prod_raw : prod_raw;
        // the most-negative / -1 case falls out naturally: the magnitude
        // quotient 2^(W-1) negates back to itself and the remainder is 0
        quo_fix  = dzf_q ? '1 : ((op_q == OP_DIV && neg_q) ? -quo_q : quo_q);
        // with a zero divisor the remainder path rebuilds a exactly
        rem_fix  = (op_q == OP_DIV && rneg_q) ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dzf_d   = dzf_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !flush) begin
                    op_d   = op_in;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    dzf_d  = op_is_div(op_in) && (b == '0);
                    cnt_d  = CW'(WIDTH - 1);
                    if (op_is_div(op_in)) begin
                        acc_d   = '0;
                        quo_d   = a_mag;
                        mcand_d = b_mag;
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        {acc_d, quo_d} = (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
                        mcand_d = a_mag;
                        state_d = ST_FIX;
                        busy_d  = 1'b0;
`else
                        acc_d   = '0;
                        quo_d   = b_mag;
                        mcand_d = a_mag;
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
`endif
                    end
                end
            end

            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (op_is_div(op_q)) begin
                        acc_d = div_ge ? (div_sh[WIDTH-1:0] - mcand_q) : div_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    dz_d   = dzf_q;
                    if (op_is_div(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dzf_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dzf_q   <= dzf_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed bench for muldiv_unit (WIDTH=32).
// A behavioural model (plain arithmetic plus a latency countdown) predicts
// busy/done/dz/hi/lo every cycle; directed vectors carry hand-computed values.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Returns {dz, hi, lo} straight from the arithmetic definition.
    function automatic logic [64:0] model_res(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] h, l;
        logic        z;
        z = 1'b0;
        case (o)
            2'b00: begin
                sx = $signed(x);
                sy = $signed(y);
                p  = sx * sy;
                {h, l} = p;
            end
            2'b01: begin
                p = 64'(x) * 64'(y);
                {h, l} = p;
            end
            2'b10: begin
                if (y == 0) begin
                    l = '1; h = x; z = 1'b1;
                end else begin
                    sx = $signed(x);
                    sy = $signed(y);
                    q  = sx / sy;
                    r  = sx % sy;
                    l  = q[31:0];
                    h  = r[31:0];
                end
            end
            default: begin
                if (y == 0) begin
                    l = '1; h = x; z = 1'b1;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
        return {z, h, l};
    endfunction

    logic         m_active = 1'b0;
    int           m_left = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dz = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [64:0]  m_res = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_left   <= 0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_dz     <= 1'b0;
            m_hi     <= '0;
            m_lo     <= '0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_active) begin
                if (flush) begin
                    m_active <= 1'b0;
                    m_busy   <= 1'b0;
                end else if (m_left == 1) begin
                    m_hi     <= m_res[63:32];
                    m_lo     <= m_res[31:0];
                    m_dz     <= m_res[64];
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                    m_busy   <= 1'b0;
                end else begin
                    m_left <= m_left - 1;
                end
            end else begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
                if (start && !flush) begin
                    m_res    <= model_res(op, a, b);
                    m_active <= 1'b1;
                    m_left   <= (FAST && !op[1]) ? 1 : W + 1;
                    m_busy   <= !(FAST && !op[1]);
                end
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        if (m_done) check("dz", 64'(dz), 64'(m_dz));
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int n;
        int lat;
        lat = (FAST && !o[1]) ? 1 : W + 1;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;              // cycle 0: start sampled on this edge
        start = 1'b0; a = $urandom; b = $urandom;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_hi"}, 64'(hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(lo), 64'(exp_lo));
        check({name, "_dz"}, 64'(dz), 64'(exp_dz));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done_cnt;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu_5_0", 2'b11, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        run_op("div_neg5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);

        // MTHI together with start: the write lands now, the result later
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'h0000_AAAA;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        check("mthi_with_start", 64'(hi), 64'h0000_AAAA);
        // MTLO while busy must be ignored
        @(posedge clk); #1;
        lo_we = 1'b1; wdata = 32'h5555_5555;
        @(posedge clk); #1;
        lo_we = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("div_9_3_hi", 64'(hi), 64'h0);
        check("div_9_3_lo", 64'(lo), 64'h3);

        // MTLO then an operation flushed mid-flight, with a stray start in RUN
        @(posedge clk); #1;
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        @(negedge clk);
        check("mtlo", 64'(lo), 64'h0000_1234);
        @(posedge clk); #1;
        start = 1'b1; op = FAST ? 2'b11 : 2'b01; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;              // cycle 0
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;                              // cycle 5
        start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd7;
        @(posedge clk); #1;              // cycle 6
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;                              // cycle 10
        flush = 1'b1;
        @(posedge clk); #1;              // cycle 11
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_c11", 64'(busy), 64'h0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("flush_no_done", 64'(done_cnt), 64'h0);
        check("flush_lo_kept", 64'(lo), 64'h0000_1234);

        // asynchronous reset in the middle of RUN
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_hi", 64'(hi), 64'h0);
        check("areset_lo", 64'(lo), 64'h0);
        check("areset_busy", 64'(busy), 64'h0);
        check("areset_done", 64'(done), 64'h0);
        @(negedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check("areset_no_done", 64'(done), 64'h0);
        end

        run_op("mult_4x5", 2'b00, 32'd4, 32'd5, 32'h0, 32'h0000_0014, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard stop in case something above never returns
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even and at least 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation this cycle.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a, b  input  WIDTH  operands (rs, rt).
REQ-007 SHALL have port flush  input  1  abort the operation in flight.
REQ-008 SHALL have ports hi_we, lo_we  input  1  MTHI/MTLO write strobes.
REQ-009 SHALL have port wdata  input  WIDTH  MTHI/MTLO data.
REQ-010 SHALL have port busy  output  1  operation in flight; core stalls MFHI/MFLO and muldiv issue.
REQ-011 SHALL have port done  output  1  one-cycle pulse when hi/lo take a new result.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag, valid while done is high.
REQ-013 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and FIX; IDLE is the reset state.
REQ-015 SHALL accept start only in IDLE; start in RUN or FIX is ignored.
REQ-016 SHALL, on acceptance, latch op and the operand magnitudes (absolute values for MULT/DIV), load counter with WIDTH-1, and enter RUN.
REQ-017 SHALL do one shift-add (multiply) or one restoring subtract-shift (divide) step per RUN cycle, then enter FIX when counter reaches 0.
REQ-018 SHALL, in FIX, apply sign correction and write hi/lo, assert done for that cycle, and return to IDLE.
REQ-019 SHALL assert done exactly WIDTH+1 cycles after the edge that sampled start; busy is high from the next cycle through the cycle before done.
REQ-020 SHALL produce for multiply: {hi,lo} = 2*WIDTH-bit product, two's complement for MULT.
REQ-021 SHALL produce for divide: lo = quotient truncated toward zero, hi = remainder with the sign of a (DIV).
REQ-022 SHALL, for b == 0, set lo = all ones, hi = a, dz = 1; all other results give dz = 0.
REQ-023 SHALL, for DIV with a = most negative and b = -1, set lo = a, hi = 0, dz = 0.
REQ-024 SHALL, on flush in RUN or FIX, return to IDLE next cycle with hi/lo unchanged and no done; flush in IDLE has no effect.
REQ-025 SHALL honour hi_we/lo_we only in IDLE (writes visible next cycle) and ignore them otherwise; simultaneous start and write in IDLE performs both.
REQ-026 SHALL give flush priority over start in the same cycle.

Reset
REQ-027 SHALL, on reset low, asynchronously force IDLE, hi = 0, lo = 0, busy = 0, done = 0, dz = 0, counter = 0, and discard any operation in flight.

Configuration
REQ-028 SHALL, with MULDIV_FAST_MUL_EN defined, complete MULT/MULTU in a single cycle: done is asserted one cycle after the start edge, busy stays 0, and RUN is skipped.
REQ-029 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiply of REQ-017; divide timing is identical in both builds.

Structure
REQ-030 SHALL take the op encodings and the FSM state encoding from shared package muldiv_pkg.
REQ-031 SHALL use no sub-module; the FSM and datapath live in muldiv_unit.

Verification
REQ-032 SHALL cover: WIDTH=32, MULT a=-3, b=7 -> done at cycle 33, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-033 SHALL cover: DIVU a=100, b=7 -> lo=0000000E, hi=00000002, dz=0.
REQ-034 SHALL cover: DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-035 SHALL cover: DIVU a=5, b=0 -> lo=FFFFFFFF, hi=00000005, dz=1 with done.
REQ-036 SHALL cover: MTLO 1234 in IDLE, then MULTU 2*3 with flush at cycle 10 -> no done, lo=00001234, busy low at cycle 11; start in RUN is ignored.
REQ-037 SHALL cover: reset low mid-RUN -> hi=lo=0, busy=0 immediately; with MULDIV_FAST_MUL_EN, MULT 4*5 -> done at cycle 1, lo=00000014.
